// File: rtl/arm_control_fsm.sv
// arm_control_fsm
// Multicycle control unit for the ARM calculator datapath. It latches one
// instruction, decodes it into immediate/ALU controls for the execution stage,
// sequences fetch/decode/execute/writeback, and holds the NZCV flag register.
// Every architectural write is gated by the condition field, which is evaluated
// against the stored flags.
// Optional feature: define ARM_CTRL_CMP_EN to accept CMP (cmd 1010).
module arm_control_fsm #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [3:0]  ALUFlags,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUSrc,
    output logic [1:0]  ALUControl,
    output logic        ir_write,
    output logic        pc_inc,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        result_src,
    output logic [3:0]  flags_q,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_ir;
    logic [3:0]  r_flags;

    // Instruction fields taken from the latched word, never from the live bus.
    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic        w_imm_op;
    logic [3:0]  w_cmd;
    logic        w_s_bit;      // S for data-processing, L for memory
    logic        w_unused_ir;

    assign w_cond      = r_ir[31:28];
    assign w_op        = r_ir[27:26];
    assign w_imm_op    = r_ir[25];
    assign w_cmd       = r_ir[24:21];
    assign w_s_bit     = r_ir[20];
    assign w_unused_ir = ^r_ir[19:0];

    // Stored flag bits.
    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Data-processing command decode.
    logic       w_dp_legal;
    logic [1:0] w_dp_ctl;
    logic       w_is_cmp;

    // Condition evaluation.
    logic w_cond_base;
    logic w_cond_ex;

    // Register-load enables produced by the FSM.
    logic w_ir_load;
    logic w_flag_load;

    // Decode the data-processing command into an ALU operation and legality.
    always_comb begin
        w_dp_legal = 1'b1;
        w_dp_ctl   = 2'b00;
        w_is_cmp   = 1'b0;
        case (w_cmd)
            4'b0100: w_dp_ctl = 2'b00;   // ADD
            4'b0010: w_dp_ctl = 2'b01;   // SUB
            4'b0000: w_dp_ctl = 2'b10;   // AND
            4'b1100: w_dp_ctl = 2'b11;   // ORR
`ifdef ARM_CTRL_CMP_EN
            4'b1010: begin               // CMP: subtract, flags only
                w_dp_ctl = 2'b01;
                w_is_cmp = 1'b1;
            end
`endif
            default: w_dp_legal = 1'b0;
        endcase
    end

    // Condition check: conditions come in complementary pairs, so evaluate the
    // even member from cond[3:1] and invert it when cond[0] is set. The 111x
    // pair then yields AL (1110) = 1 and 1111 = 0 with no special case.
    always_comb begin
        case (w_cond[3:1])
            3'b000:  w_cond_base = w_z;                          // EQ / NE
            3'b001:  w_cond_base = w_c;                          // CS / CC
            3'b010:  w_cond_base = w_n;                          // MI / PL
            3'b011:  w_cond_base = w_v;                          // VS / VC
            3'b100:  w_cond_base = w_c & ~w_z;                   // HI / LS
            3'b101:  w_cond_base = ~(w_n ^ w_v);                 // GE / LT
            3'b110:  w_cond_base = ~w_z & ~(w_n ^ w_v);          // GT / LE
            default: w_cond_base = 1'b1;                         // AL / never
        endcase
        w_cond_ex = w_cond_base ^ w_cond[0];
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Instruction register, loaded only on an accepted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= '0;
        end else if (w_ir_load) begin
            r_ir <= instr;
        end
    end

    // NZCV register, updated at the edge that ends ALU writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= RESET_FLAGS;
        end else if (w_flag_load) begin
            r_flags <= ALUFlags;
        end
    end

    // Next-state and control outputs; everything defaults to idle.
    always_comb begin
        w_state_next = r_state;
        ImmSrc       = 2'b00;
        ALUSrc       = 2'b00;
        ALUControl   = 2'b00;
        ir_write     = 1'b0;
        pc_inc       = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        result_src   = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        w_ir_load    = 1'b0;
        w_flag_load  = 1'b0;

        case (r_state)
            S_FETCH: begin
                // Gate with rst_n so a valid held during reset is not reported
                // as accepted while the registers are still cleared.
                w_ir_load = instr_valid & rst_n;
                ir_write  = w_ir_load;
                pc_inc    = w_ir_load;
                if (instr_valid) begin
                    w_state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                case (w_op)
                    2'b00: begin
                        if (w_dp_legal) begin
                            w_state_next = S_EXEC;
                        end else begin
                            illegal      = 1'b1;
                            w_state_next = S_FETCH;
                        end
                    end
                    2'b01:   w_state_next = S_MEMADR;
                    2'b10:   w_state_next = S_BRANCH;
                    default: begin
                        illegal      = 1'b1;
                        w_state_next = S_FETCH;
                    end
                endcase
            end

            S_EXEC: begin
                ImmSrc       = 2'b00;
                ALUSrc       = {1'b0, w_imm_op};
                ALUControl   = w_dp_ctl;
                w_state_next = S_ALUWB;
            end

            S_ALUWB: begin
                ImmSrc       = 2'b00;
                ALUSrc       = {1'b0, w_imm_op};
                ALUControl   = w_dp_ctl;
                reg_write    = w_cond_ex & ~w_is_cmp;
                result_src   = 1'b0;
                w_flag_load  = w_cond_ex & (w_s_bit | w_is_cmp);
                done         = 1'b1;
                w_state_next = S_FETCH;
            end

            S_MEMADR: begin
                ImmSrc       = 2'b01;
                ALUSrc       = 2'b01;
                ALUControl   = 2'b00;
                w_state_next = w_s_bit ? S_MEMRD : S_MEMWR;
            end

            S_MEMRD: begin
                mem_read     = 1'b1;
                w_state_next = S_MEMWB;
            end

            S_MEMWB: begin
                mem_read     = 1'b1;
                result_src   = 1'b1;
                reg_write    = w_cond_ex;
                done         = 1'b1;
                w_state_next = S_FETCH;
            end

            S_MEMWR: begin
                mem_write    = w_cond_ex;
                done         = 1'b1;
                w_state_next = S_FETCH;
            end

            S_BRANCH: begin
                ImmSrc       = 2'b10;
                ALUSrc       = 2'b10;
                ALUControl   = 2'b00;
                pc_write     = w_cond_ex;
                done         = 1'b1;
                w_state_next = S_FETCH;
            end

            default: w_state_next = S_FETCH;
        endcase
    end

    assign flags_q = r_flags;

endmodule

// File: tb/tb_arm_control_fsm.sv
// tb_arm_control_fsm
// Scoreboard bench: each instruction pushes its expected per-cycle control
// trace (built from the instruction class and a bench-side flag model) into a
// queue; the trace is popped and compared cycle by cycle as the DUT runs.
module tb_arm_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [3:0]  ALUFlags = 4'h0;
    logic [1:0]  ImmSrc, ALUSrc, ALUControl;
    logic        ir_write, pc_inc, pc_write, reg_write;
    logic        mem_read, mem_write, result_src, done, illegal;
    logic [3:0]  flags_q;

    arm_control_fsm #(.RESET_FLAGS(4'b0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .ALUFlags    (ALUFlags),
        .ImmSrc      (ImmSrc),
        .ALUSrc      (ALUSrc),
        .ALUControl  (ALUControl),
        .ir_write    (ir_write),
        .pc_inc      (pc_inc),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .result_src  (result_src),
        .flags_q     (flags_q),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] imm;
        logic [1:0] asrc;
        logic [1:0] actl;
        logic       irw;
        logic       pci;
        logic       pcw;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       rs;
        logic       dn;
        logic       ill;
        logic [3:0] f;
    } obs_t;

    obs_t w_obs;
    assign w_obs = {ImmSrc, ALUSrc, ALUControl, ir_write, pc_inc, pc_write,
                    reg_write, mem_read, mem_write, result_src, done, illegal,
                    flags_q};

    int    err_cnt = 0;
    int    chk_cnt = 0;
    obs_t  exp_q[$];
    string tag_q[$];
    logic [3:0] m_flags = 4'b0000;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
        logic n, z, cy, v;
        {n, z, cy, v} = fl;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input string t, input logic [31:0] ins, input obs_t v);
        exp_q.push_back(v);
        tag_q.push_back($sformatf("%s@%h", t, ins));
    endtask

    // Expected trace for one instruction, starting in its FETCH cycle.
    task automatic build(input logic [31:0] ins, input logic [3:0] af, input bit idle);
        obs_t b, e;
        logic ce, legal, cmp;
        logic [1:0] ac;
        ce = cond_ok(ins[31:28], m_flags);
        b = '0;
        b.f = m_flags;
        e = b; e.irw = 1'b1; e.pci = 1'b1;
        push("fetch", ins, e);
        legal = 1'b1; cmp = 1'b0; ac = 2'd0;
        case (ins[27:26])
            2'b00: begin
                case (ins[24:21])
                    4'b0100: ac = 2'd0;
                    4'b0010: ac = 2'd1;
                    4'b0000: ac = 2'd2;
                    4'b1100: ac = 2'd3;
`ifdef ARM_CTRL_CMP_EN
                    4'b1010: begin ac = 2'd1; cmp = 1'b1; end
`endif
                    default: legal = 1'b0;
                endcase
                if (!legal) begin
                    e = b; e.ill = 1'b1;
                    push("decode_illegal", ins, e);
                end else begin
                    push("decode", ins, b);
                    e = b; e.asrc = {1'b0, ins[25]}; e.actl = ac;
                    push("exec", ins, e);
                    e.rw = ce & ~cmp; e.dn = 1'b1;
                    push("aluwb", ins, e);
                    if (ce && (ins[20] || cmp)) m_flags = af;
                end
            end
            2'b01: begin
                push("decode", ins, b);
                e = b; e.imm = 2'd1; e.asrc = 2'd1;
                push("memadr", ins, e);
                if (ins[20]) begin
                    e = b; e.mr = 1'b1;
                    push("memrd", ins, e);
                    e.rs = 1'b1; e.rw = ce; e.dn = 1'b1;
                    push("memwb", ins, e);
                end else begin
                    e = b; e.mw = ce; e.dn = 1'b1;
                    push("memwr", ins, e);
                end
            end
            2'b10: begin
                push("decode", ins, b);
                e = b; e.imm = 2'd2; e.asrc = 2'd2; e.pcw = ce; e.dn = 1'b1;
                push("branch", ins, e);
            end
            default: begin
                e = b; e.ill = 1'b1;
                push("decode_illegal", ins, e);
            end
        endcase
        if (idle) begin
            e = '0; e.f = m_flags;
            push("idle", ins, e);
        end
    endtask

    // Called one step after a rising edge with the DUT in FETCH.
    task automatic run(input logic [31:0] ins, input logic [3:0] af, input bit idle);
        obs_t  e;
        string t;
        build(ins, af, idle);
        $display("instr %h aluflags %b model_flags_after %b", ins, af, m_flags);
        instr       = ins;
        ALUFlags    = af;
        instr_valid = 1'b1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_val(t, 32'(w_obs), 32'(e));
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
            instr       = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset: everything idle, flags at their reset value.
        #2;
        check_val("por_outputs", 32'(w_obs), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_flags = 4'b0000;

        run(32'hE0821003, 4'b1111, 1'b1);   // ADD R1,R2,R3: no flag update
        run(32'hE2921005, 4'b0100, 1'b1);   // ADDS R1,R2,#5: flags <- 0100
        run(32'h0A000004, 4'b0000, 1'b0);   // BEQ taken (Z=1), back-to-back
        run(32'hE2921005, 4'b0000, 1'b0);   // ADDS: flags <- 0000
        run(32'h0A000004, 4'b0000, 1'b1);   // BEQ not taken, done still pulses
        run(32'hE5921004, 4'b0000, 1'b0);   // LDR
        run(32'hE5821004, 4'b0000, 1'b1);   // STR
        run(32'hE0221003, 4'b0000, 1'b1);   // EOR: illegal
        run(32'hE0421003, 4'b0000, 1'b0);   // SUB
        run(32'hE0021003, 4'b0000, 1'b0);   // AND
        run(32'hE1821003, 4'b0000, 1'b1);   // ORR
        run(32'hFC000000, 4'b0000, 1'b1);   // op=11: illegal
        run(32'hE1520003, 4'b1001, 1'b1);   // CMP: legal only with the option
        run(32'hE2921005, 4'b1000, 1'b1);   // ADDS: flags <- 1000 (N, !V)
        run(32'hBA000001, 4'b0000, 1'b0);   // BLT taken
        run(32'hAA000001, 4'b0000, 1'b0);   // BGE not taken
        run(32'h02921005, 4'b1111, 1'b1);   // ADDSEQ failed: no write, no flags
        run(32'hF0821003, 4'b0000, 1'b1);   // cond 1111: never executes
        run(32'h15921004, 4'b0000, 1'b0);   // LDRNE executes
        run(32'h05821004, 4'b0000, 1'b1);   // STREQ suppressed
        run(32'hE2921005, 4'b0110, 1'b0);   // ADDS: flags <- 0110

        // Reset in the middle of EXEC of an ADD.
        $display("instr %h reset asserted during EXEC", 32'hE0821003);
        instr       = 32'hE0821003;
        ALUFlags    = 4'b1111;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #2;
        check_val("pre_reset_flags", 32'(flags_q), 32'(4'b0110));
        rst_n = 1'b0;
        #1;
        check_val("reset_async_outputs", 32'(w_obs), 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_val("reset_hold_outputs", 32'(w_obs), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_flags = 4'b0000;
        run(32'hEA000000, 4'b0000, 1'b1);   // B AL from FETCH after reset

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/arm_control_fsm.md
Name: arm_control_fsm

Overview:
- Multicycle control unit for the ARM calculator datapath; the initiating end of the execution stage interface.
- Latches one instruction and decodes it into ImmSrc, ALUSrc and ALUControl for the execution stage.
- Sequences fetch/decode/execute/writeback, holds the NZCV flag register, evaluates the condition field, and gates every architectural write.

Parameters:
RESET_FLAGS, 4'b0000, flag register value after reset ({N,Z,C,V})

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
instr_valid  input  1  fetch handshake: instr is valid this cycle
instr  input  32  instruction word
ALUFlags  input  4  execution-stage flags {N,Z,C,V} = [3:0]
ImmSrc  output  2  00 imm8 (data-proc), 01 imm12 (memory), 10 imm24 (branch)
ALUSrc  output  2  00 RD2, 01 ExtImm, 10 ExtImm<<2, 11 all-ones (never driven by this block)
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ir_write  output  1  latch instruction / fetch accept
pc_inc  output  1  PC <= PC+4
pc_write  output  1  PC <= ALUResult (taken branch)
reg_write  output  1  register-file write of result to Rd
mem_read  output  1  data-memory read
mem_write  output  1  data-memory write
result_src  output  1  0 ALUResult, 1 memory data
flags_q  output  4  current NZCV register
done  output  1  one-cycle pulse, instruction retired
illegal  output  1  one-cycle pulse, instruction rejected

Behaviour:
- Reset (async, rst_n=0): state=FETCH, IR=0, flags_q=RESET_FLAGS, all other outputs 0. Takes effect mid-instruction: no write completes.
- Reset values and idle defaults: ImmSrc/ALUSrc/ALUControl = 00 outside EXEC/ALUWB/MEMADR/BRANCH.
- FETCH: ir_write=pc_inc=instr_valid. On instr_valid, IR<=instr and go to DECODE; otherwise stay in FETCH. instr is ignored after capture.
- Condition logic, evaluated on the IR against flags_q (not the live ALUFlags), giving CondEx:
  - cond[31:28] decodes as EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL.
  - 1111 gives CondEx=0.
- DECODE, decode of op=IR[27:26]:
  - op=00, I=IR[25], cmd=IR[24:21], S=IR[20]:
    - ADD 0100 -> ALUControl 00; SUB 0010 -> 01; AND 0000 -> 10; ORR 1100 -> 11.
    - Any other cmd -> illegal.
    - Next state is EXEC.
  - op=01 (LDR/STR, L=IR[20]) -> MEMADR.
  - op=10 (B) -> BRANCH.
  - op=11 -> illegal.
  - Illegal instruction: illegal=1 for one cycle, return to FETCH, no writes, no done.
- EXEC: drive ImmSrc=00; ALUSrc=01 if I else 00; ALUControl per cmd. Next state ALUWB.
- ALUWB:
  - Same controls as EXEC.
  - reg_write=CondEx, result_src=0.
  - If S and CondEx: flags_q<=ALUFlags at the clock edge ending ALUWB.
  - done=1; next state FETCH.
- MEMADR: ImmSrc=01, ALUSrc=01, ALUControl=00. Next state MEMRD if L, else MEMWR.
- MEMRD: mem_read=1; next state MEMWB.
- MEMWB: mem_read=1, result_src=1, reg_write=CondEx, done=1; next state FETCH.
- MEMWR: mem_write=CondEx, done=1; next state FETCH.
- BRANCH: ImmSrc=10, ALUSrc=10, ALUControl=00, pc_write=CondEx, done=1; next state FETCH.
- Latency from instr_valid acceptance to done, counted with FETCH as cycle 1:
  - Data-processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
- Back-to-back: FETCH follows the done cycle, so there is zero bubble beyond the state sequence.
- Failed condition: the full state sequence still runs and done still pulses, but all writes and the flag update are suppressed.

Optional Feature:
- Macro: ARM_CTRL_CMP_EN.
- Defined: cmd 1010 (CMP) is legal.
  - ALUControl=01.
  - reg_write forced 0.
  - Flags update whenever CondEx, regardless of S.
  - Same 4-cycle latency.
- Undefined: cmd 1010 is illegal, as for other unsupported cmds.

Test Plan:
- Reset with rst_n=0 mid-EXEC of 0xE0821003 -> all outputs 0 immediately, flags_q=RESET_FLAGS, state FETCH; reg_write never pulses.
- ADD R1,R2,R3 (0xE0821003), then ADDS R1,R2,#5 (0xE2921005) with ALUFlags=4'b0100:
  - ADD: ALUSrc=00, ALUControl=00, reg_write in cycle 4, flags_q unchanged.
  - ADDS: ALUSrc=01, ImmSrc=00; flags_q=0100 after ALUWB.
- BEQ (0x0A000004):
  - flags_q Z=1 -> ImmSrc=10, ALUSrc=10, pc_write=1, done in cycle 3.
  - Z=0 -> pc_write=0, done still pulses.
- LDR R1,[R2,#4] (0xE5921004) -> ImmSrc=01, ALUSrc=01; mem_read in cycles 4-5; reg_write with result_src=1 in cycle 5.
- STR R1,[R2,#4] (0xE5821004) -> mem_write=1 in cycle 4, reg_write stays 0.
- EOR (0xE0221003) -> illegal pulse in cycle 2, no writes, FETCH in cycle 3.
- CMP R2,R3 (0xE1520003):
  - With ARM_CTRL_CMP_EN: ALUControl=01, flags_q<=ALUFlags, no reg_write.
  - Without ARM_CTRL_CMP_EN: illegal pulse.
